// File: rtl/axis_port_stats_stamp.sv
// Multi-channel AXI4-Stream pass-through: per-channel registered skid slice,
// packet/byte statistics counters and optional SOF time stamp in TUSER.
module axis_port_stats_stamp #(
  parameter int C_DATA_WIDTH       = 256,
  parameter int C_TUSER_WIDTH      = 128,
  parameter int NUM_PORTS          = 4,
  parameter int C_PKT_COUNT_DWIDTH = 64,
  parameter int TIME_STAMP_DWIDTH  = 64,
  parameter int TS_POS             = 64,
  parameter int STAMP_EN           = 1
) (
  input  logic                                       axi_aclk,
  input  logic                                       axi_resetn,
  input  logic [TIME_STAMP_DWIDTH-1:0]               counter_val,
  input  logic [NUM_PORTS*C_DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [NUM_PORTS*C_DATA_WIDTH/8-1:0]        s_axis_tstrb,
  input  logic [NUM_PORTS*C_TUSER_WIDTH-1:0]         s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                       s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                       s_axis_tready,
  input  logic [NUM_PORTS-1:0]                       s_axis_tlast,
  output logic [NUM_PORTS*C_DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [NUM_PORTS*C_DATA_WIDTH/8-1:0]        m_axis_tstrb,
  output logic [NUM_PORTS*C_TUSER_WIDTH-1:0]         m_axis_tuser,
  output logic [NUM_PORTS-1:0]                       m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                       m_axis_tready,
  output logic [NUM_PORTS-1:0]                       m_axis_tlast,
  input  logic [NUM_PORTS-1:0]                       clear_stats,
  output logic [NUM_PORTS*C_PKT_COUNT_DWIDTH-1:0]    pkt_count,
  output logic [NUM_PORTS*C_PKT_COUNT_DWIDTH-1:0]    byte_count
);

  localparam int STRB_W = C_DATA_WIDTH / 8;
  // One beat packed as {last, user, strb, data}
  localparam int BEAT_W = C_DATA_WIDTH + STRB_W + C_TUSER_WIDTH + 1;

  typedef enum logic {ST_SOF, ST_MID} state_t;

  function automatic logic [C_PKT_COUNT_DWIDTH-1:0] popcount(input logic [STRB_W-1:0] v);
    logic [C_PKT_COUNT_DWIDTH-1:0] n;
    n = '0;
    for (int b = 0; b < STRB_W; b++) n = n + C_PKT_COUNT_DWIDTH'(v[b]);
    return n;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ch
      logic [C_TUSER_WIDTH-1:0]      in_user;
      logic [BEAT_W-1:0]             in_beat;
      logic                          accept;
      logic                          pop;
      state_t                        state_reg, state_next;
      logic                          ready_reg;
      logic                          main_valid_reg, main_valid_next;
      logic                          skid_valid_reg, skid_valid_next;
      logic [BEAT_W-1:0]             main_beat_reg, main_beat_next;
      logic [BEAT_W-1:0]             skid_beat_reg, skid_beat_next;
      logic [C_PKT_COUNT_DWIDTH-1:0] pkt_reg, pkt_next;
      logic [C_PKT_COUNT_DWIDTH-1:0] byte_reg, byte_next;

      assign accept = s_axis_tvalid[gi] & ready_reg;
      assign pop    = main_valid_reg & m_axis_tready[gi];

      // Stamp field replaced with the current time only on the first beat of a packet
      if (STAMP_EN != 0) begin : g_stamp
        always_comb begin
          in_user = s_axis_tuser[gi*C_TUSER_WIDTH +: C_TUSER_WIDTH];
          if (state_reg == ST_SOF) in_user[TS_POS +: TIME_STAMP_DWIDTH] = counter_val;
        end
      end else begin : g_nostamp
        assign in_user = s_axis_tuser[gi*C_TUSER_WIDTH +: C_TUSER_WIDTH];
      end

      assign in_beat = {s_axis_tlast[gi], in_user,
                        s_axis_tstrb[gi*STRB_W +: STRB_W],
                        s_axis_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH]};

      // SOF/MID tracking on accepted beats
      always_comb begin
        state_next = state_reg;
        if (accept) state_next = s_axis_tlast[gi] ? ST_SOF : ST_MID;
      end

      // Skid slice: main feeds the output, skid catches the beat accepted while main stalls
      always_comb begin
        main_valid_next = main_valid_reg;
        main_beat_next  = main_beat_reg;
        skid_valid_next = skid_valid_reg;
        skid_beat_next  = skid_beat_reg;
        if (!main_valid_reg || pop) begin
          if (skid_valid_reg) begin
            main_valid_next = 1'b1;
            main_beat_next  = skid_beat_reg;
            skid_valid_next = 1'b0;
          end else begin
            main_valid_next = accept;
            if (accept) main_beat_next = in_beat;
          end
        end else if (accept) begin
          skid_valid_next = 1'b1;
          skid_beat_next  = in_beat;
        end
      end

      // Statistics: a coincident clear drops the old value but keeps this cycle's increment
      always_comb begin
        pkt_next  = clear_stats[gi] ? '0 : pkt_reg;
        byte_next = clear_stats[gi] ? '0 : byte_reg;
        if (accept) begin
          byte_next = byte_next + popcount(s_axis_tstrb[gi*STRB_W +: STRB_W]);
          if (s_axis_tlast[gi]) pkt_next = pkt_next + 1'b1;
        end
      end

      // State, slice and counter registers
      always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
          state_reg      <= ST_SOF;
          ready_reg      <= 1'b0;
          main_valid_reg <= 1'b0;
          skid_valid_reg <= 1'b0;
          main_beat_reg  <= '0;
          skid_beat_reg  <= '0;
          pkt_reg        <= '0;
          byte_reg       <= '0;
        end else begin
          state_reg      <= state_next;
          ready_reg      <= !skid_valid_next;
          main_valid_reg <= main_valid_next;
          skid_valid_reg <= skid_valid_next;
          main_beat_reg  <= main_beat_next;
          skid_beat_reg  <= skid_beat_next;
          pkt_reg        <= pkt_next;
          byte_reg       <= byte_next;
        end
      end

      assign s_axis_tready[gi] = ready_reg;
      assign m_axis_tvalid[gi] = main_valid_reg;
      assign m_axis_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH] = main_beat_reg[0 +: C_DATA_WIDTH];
      assign m_axis_tstrb[gi*STRB_W +: STRB_W]             = main_beat_reg[C_DATA_WIDTH +: STRB_W];
      assign m_axis_tuser[gi*C_TUSER_WIDTH +: C_TUSER_WIDTH] =
        main_beat_reg[C_DATA_WIDTH+STRB_W +: C_TUSER_WIDTH];
      assign m_axis_tlast[gi] = main_beat_reg[BEAT_W-1];
      assign pkt_count[gi*C_PKT_COUNT_DWIDTH +: C_PKT_COUNT_DWIDTH]  = pkt_reg;
      assign byte_count[gi*C_PKT_COUNT_DWIDTH +: C_PKT_COUNT_DWIDTH] = byte_reg;
    end
  endgenerate

endmodule

// File: tb/tb_axis_port_stats_stamp.sv
// Randomized scoreboard bench for axis_port_stats_stamp.
module tb_axis_port_stats_stamp;
  localparam int DW = 64, UW = 128, NP = 4, CW = 8, TW = 64, TSP = 32, SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [TW-1:0]      counter_val = '0;
  logic [NP*DW-1:0]   s_axis_tdata = '0, m_axis_tdata;
  logic [NP*SW-1:0]   s_axis_tstrb = '0, m_axis_tstrb;
  logic [NP*UW-1:0]   s_axis_tuser = '0, m_axis_tuser;
  logic [NP-1:0]      s_axis_tvalid = '0, s_axis_tready, s_axis_tlast = '0;
  logic [NP-1:0]      m_axis_tvalid, m_axis_tready = '0, m_axis_tlast, clear_stats = '0;
  logic [NP*CW-1:0]   pkt_count, byte_count;

  axis_port_stats_stamp #(
    .C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW), .NUM_PORTS(NP), .C_PKT_COUNT_DWIDTH(CW),
    .TIME_STAMP_DWIDTH(TW), .TS_POS(TSP), .STAMP_EN(1)
  ) dut (
    .axi_aclk(clk), .axi_resetn(rst_n), .counter_val(counter_val),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .clear_stats(clear_stats), .pkt_count(pkt_count), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          l;
    logic [UW-1:0] u;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
  } beat_t;

  int    n_checks = 0, n_fail = 0;
  int    cycle = 0;
  int    edges_since_rst = 0;
  // reference model state
  beat_t exp_q[NP][$];
  int    tot_pkts[NP], tot_bytes[NP], acc_cnt[NP];
  bit    msof[NP], acc_pend[NP], held_v[NP];
  beat_t held[NP];
  // stimulus control
  int    pkts_left[NP], pkt_rem[NP], vpct[NP], rpct[NP];
  int    minlen = 1, maxlen = 1;
  bit    ones_strb = 1'b1, clr_rand = 1'b0, clr_tlast2 = 1'b0;

  function automatic void check(string name, int ch, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %0h expected %0h", name, ch, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) edges_since_rst <= 0;
    else        edges_since_rst <= edges_since_rst + 1;
  end

  // Monitor / scoreboard: everything sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        exp_q[i].delete();
        tot_pkts[i] = 0; tot_bytes[i] = 0; acc_cnt[i] = 0;
        msof[i] = 1'b1; acc_pend[i] = 1'b0; held_v[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        beat_t got, exp_b;
        got.l = m_axis_tlast[i];
        got.u = m_axis_tuser[i*UW +: UW];
        got.s = m_axis_tstrb[i*SW +: SW];
        got.d = m_axis_tdata[i*DW +: DW];
        // counters reflect every accept up to the last rising edge
        check("pkt_count", i, 256'(tot_pkts[i] % (1 << CW)), 256'(pkt_count[i*CW +: CW]) ^ 256'(0));
        check("byte_count", i, 256'(byte_count[i*CW +: CW]), 256'(tot_bytes[i] % (1 << CW)));
        if (held_v[i]) begin
          check("hold_valid", i, 256'(m_axis_tvalid[i]), 256'(1));
          check("hold_beat", i, 256'(got), 256'(held[i]));
        end
        if (m_axis_tvalid[i] && m_axis_tready[i]) begin
          if (exp_q[i].size() == 0) begin
            check("unexpected_beat", i, 256'(got), 256'(0) - 256'(1));
          end else begin
            exp_b = exp_q[i].pop_front();
            check("beat", i, 256'(got), 256'(exp_b));
            $display("ch%0d out data=%h strb=%h last=%b stamp=%h", i, got.d, got.s, got.l,
                     got.u[TSP +: TW]);
          end
        end
        if (!m_axis_tvalid[i] && edges_since_rst >= 1)
          check("s_tready_idle", i, 256'(s_axis_tready[i]), 256'(1));
        held_v[i] = m_axis_tvalid[i] && !m_axis_tready[i];
        held[i]   = got;
        // model the edge that follows this negedge
        if (clear_stats[i]) begin tot_pkts[i] = 0; tot_bytes[i] = 0; end
        acc_pend[i] = s_axis_tvalid[i] && s_axis_tready[i];
        if (acc_pend[i]) begin
          exp_b.l = s_axis_tlast[i];
          exp_b.u = s_axis_tuser[i*UW +: UW];
          exp_b.s = s_axis_tstrb[i*SW +: SW];
          exp_b.d = s_axis_tdata[i*DW +: DW];
          if (msof[i]) exp_b.u[TSP +: TW] = counter_val;
          exp_q[i].push_back(exp_b);
          tot_bytes[i] += $countones(exp_b.s);
          if (exp_b.l) tot_pkts[i]++;
          msof[i] = exp_b.l;
          acc_cnt[i]++;
        end
      end
    end
  end

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    cycle++;
    counter_val = TW'(64'h1000 + 64'(cycle));
    clear_stats = '0;
    for (int i = 0; i < NP; i++) begin
      if (acc_pend[i]) s_axis_tvalid[i] = 1'b0;
      if (!s_axis_tvalid[i] && pkts_left[i] > 0 && $urandom_range(99) < 32'(vpct[i])) begin
        if (pkt_rem[i] == 0) pkt_rem[i] = int'($urandom_range(32'(maxlen), 32'(minlen)));
        s_axis_tdata[i*DW +: DW] = {$urandom, $urandom};
        s_axis_tuser[i*UW +: UW] = {$urandom, $urandom, $urandom, $urandom};
        if (ones_strb)                     s_axis_tstrb[i*SW +: SW] = '1;
        else if ($urandom_range(9) == 0)   s_axis_tstrb[i*SW +: SW] = '0;
        else                               s_axis_tstrb[i*SW +: SW] = SW'($urandom);
        pkt_rem[i]--;
        s_axis_tlast[i] = (pkt_rem[i] == 0);
        if (pkt_rem[i] == 0) pkts_left[i]--;
        s_axis_tvalid[i] = 1'b1;
      end
      m_axis_tready[i] = ($urandom_range(99) < 32'(rpct[i]));
      if (clr_rand && $urandom_range(99) < 5) clear_stats[i] = 1'b1;
    end
    if (clr_tlast2 && s_axis_tvalid[2] && s_axis_tlast[2] && s_axis_tready[2]) clear_stats[2] = 1'b1;
  endtask

  function automatic bit idle();
    bit r = 1'b1;
    for (int i = 0; i < NP; i++)
      if (pkts_left[i] != 0 || s_axis_tvalid[i] || exp_q[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic run_until_idle(string name, int budget);
    int k = 0;
    while (!idle() && k < budget) begin drive_cycle(); k++; end
    if (k >= budget) check({name, "_timeout"}, 0, 256'(k), 256'(0));
    for (int i = 0; i < NP; i++) rpct[i] = 100;
    repeat (3) drive_cycle();
  endtask

  task automatic setup(int v, int r);
    for (int i = 0; i < NP; i++) begin vpct[i] = v; rpct[i] = r; pkts_left[i] = 0; end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    s_axis_tvalid = '0; clear_stats = '0; m_axis_tready = '0;
    for (int i = 0; i < NP; i++) begin pkt_rem[i] = 0; pkts_left[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 for (int i = 0; i < NP; i++) check("s_tready_before_edge", i, 256'(s_axis_tready[i]), 256'(0));
  endtask

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    // 1: 3-beat packet on ch0, full strobes, sink always ready
    reset_dut();
    setup(100, 100);
    minlen = 3; maxlen = 3; ones_strb = 1'b1;
    pkts_left[0] = 1;
    run_until_idle("p1", 50);
    check("p1_pkt_count", 0, 256'(pkt_count[0 +: CW]), 256'(1));
    check("p1_byte_count", 0, 256'(byte_count[0 +: CW]), 256'(3 * SW));
    for (int i = 1; i < NP; i++) begin
      check("p1_other_pkt", i, 256'(pkt_count[i*CW +: CW]), 256'(0));
      check("p1_other_byte", i, 256'(byte_count[i*CW +: CW]), 256'(0));
    end

    // 2: single-beat packet on ch1, stamped
    setup(100, 100);
    minlen = 1; maxlen = 1;
    pkts_left[1] = 1;
    run_until_idle("p2", 50);

    // 3: random traffic on all channels with backpressure and random clears
    setup(70, 50);
    vpct[0] = 100;
    minlen = 1; maxlen = 5; ones_strb = 1'b0; clr_rand = 1'b1;
    for (int i = 0; i < NP; i++) pkts_left[i] = 8;
    pkts_left[0] = 6;
    run_until_idle("p3", 2000);
    clr_rand = 1'b0;

    // 4: wrap of the 8-bit packet counter; clear coincident with tlast on ch2
    reset_dut();
    setup(100, 100);
    minlen = 1; maxlen = 1; ones_strb = 1'b1; clr_tlast2 = 1'b1;
    pkts_left[3] = 256;
    pkts_left[2] = 10;
    run_until_idle("p4", 1000);
    clr_tlast2 = 1'b0;
    check("p4_wrap_pkt", 3, 256'(pkt_count[3*CW +: CW]), 256'(0));
    check("p4_clear_pkt", 2, 256'(pkt_count[2*CW +: CW]), 256'(1));
    check("p4_clear_byte", 2, 256'(byte_count[2*CW +: CW]), 256'(SW));

    // 5: reset in the middle of a 4-beat packet, then a fresh packet
    setup(100, 100);
    minlen = 4; maxlen = 4;
    pkts_left[0] = 1;
    for (int k = 0; k < 50 && acc_cnt[0] < 2; k++) drive_cycle();
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NP; i++) begin
      check("rst_m_tvalid", i, 256'(m_axis_tvalid[i]), 256'(0));
      check("rst_s_tready", i, 256'(s_axis_tready[i]), 256'(0));
      check("rst_pkt_count", i, 256'(pkt_count[i*CW +: CW]), 256'(0));
      check("rst_byte_count", i, 256'(byte_count[i*CW +: CW]), 256'(0));
    end
    check("rst_m_tdata", 0, 256'(m_axis_tdata), 256'(0));
    reset_dut();
    setup(100, 60);
    minlen = 3; maxlen = 3; ones_strb = 1'b0;
    pkts_left[0] = 2;
    run_until_idle("p5", 200);

    for (int i = 0; i < NP; i++) check("drained", i, 256'(exp_q[i].size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
